tristate_bus_reader: RTL and testbench

Receiving end of the shared tri-state data bus. Up to N_SRC sources each drive the bus through their own `tristatebuffer` instance; this block arbitrates among their requests and issues the one-hot drive enables. It inserts a mandatory turnaround cycle so no two buffers ever drive together, and samples the resolved bus value. Captured words, tagged with source index, leave through a small FIFO with a valid/ready handshake toward the consuming logic.

---
 rtl/tristate_bus_reader_pkg.sv | 19 +
 rtl/tristate_bus_reader_rr_arbiter.sv | 35 +++
 rtl/tristate_bus_reader.sv | 130 +++++++++++++
 tb/tb_tristate_bus_reader.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tristate_bus_reader_pkg.sv
// Shared definitions for the tri-state bus reader: FSM encoding, default sizes
// and a modular index helper used by the arbiter pointer and FIFO pointers.
package tristate_bus_reader_pkg;

    localparam int DEFAULT_N_SRC = 4;
    localparam int DEFAULT_DW    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        TURN  = 2'd2
    } bus_state_t;

    // Increment with wrap-around, valid for any modulus (not only powers of two).
    function automatic int next_index(input int idx, input int modulus);
        return (idx + 1 >= modulus) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/tristate_bus_reader_rr_arbiter.sv
// Combinational round-robin arbiter: searches req upward from ptr, wrapping,
// and returns the first set bit as both a one-hot vector and an index.
module rr_arbiter #(
    parameter  int N_SRC = 4,
    localparam int SW    = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    input  logic [SW-1:0]    ptr,
    output logic [N_SRC-1:0] winner_onehot,
    output logic [SW-1:0]    winner_idx,
    output logic             winner_valid
);

    always_comb begin
        int            cand;
        logic [SW-1:0] cand_idx;
        // NOTE: every output gets a default before the loop; otherwise the
        // paths where no bit wins would infer latches.
        winner_onehot = '0;
        winner_idx    = '0;
        winner_valid  = 1'b0;
        cand          = 0;
        cand_idx      = '0;
        for (int i = 0; i < N_SRC; i++) begin
            cand     = (int'(ptr) + i) % N_SRC;
            cand_idx = SW'(cand);
            if (!winner_valid && req[cand_idx]) begin
                winner_valid            = 1'b1;
                winner_idx              = cand_idx;
                winner_onehot[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tristate_bus_reader.sv
// Receiving end of the shared tri-state bus: round-robin grants with a
// mandatory turnaround cycle, bus capture, and a small tagged output FIFO.
module tristate_bus_reader
    import tristate_bus_reader_pkg::*;
#(
    parameter  int N_SRC = DEFAULT_N_SRC,
    parameter  int DW    = DEFAULT_DW,
    parameter  int DEPTH = 2,
    localparam int SW    = $clog2(N_SRC)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] req,
    output logic [N_SRC-1:0] gnt,
    input  logic [DW-1:0]    bus_in,
    output logic [DW-1:0]    out_data,
    output logic [SW-1:0]    out_src,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    bus_state_t       state_q, state_d;
    logic [SW-1:0]    winner_q, winner_d;
    logic [N_SRC-1:0] winner_oh_q, winner_oh_d;
    logic [SW-1:0]    ptr_q;

    logic [N_SRC-1:0] arb_onehot;
    logic [SW-1:0]    arb_idx;
    logic             arb_valid;

    logic [DW-1:0]    mem_data [DEPTH];
    logic [SW-1:0]    mem_src  [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;

    logic push, pop, has_room, eligible;

    rr_arbiter #(
        .N_SRC(N_SRC)
    ) u_arbiter (
        .req          (req),
        .ptr          (ptr_q),
        .winner_onehot(arb_onehot),
        .winner_idx   (arb_idx),
        .winner_valid (arb_valid)
    );

    // A grant reserves a FIFO slot: there must be room now, or a pop this cycle.
    assign pop      = out_valid & out_ready;
    assign push     = (state_q == DRIVE);
    assign has_room = (count < CW'(DEPTH));
    assign eligible = (state_q != DRIVE) && arb_valid && (has_room || pop);

    always_comb begin
        state_d     = state_q;
        winner_d    = winner_q;
        winner_oh_d = winner_oh_q;
        unique case (state_q)
            IDLE, TURN: begin
                if (eligible) begin
                    state_d     = DRIVE;
                    winner_d    = arb_idx;
                    winner_oh_d = arb_onehot;
                end else begin
                    state_d = IDLE;
                end
            end
            DRIVE:   state_d = TURN;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            winner_q    <= '0;
            winner_oh_q <= '0;
            ptr_q       <= '0;
        end else begin
            state_q     <= state_d;
            winner_q    <= winner_d;
            winner_oh_q <= winner_oh_d;
            if (push) begin
                ptr_q <= SW'(next_index(int'(winner_q), N_SRC));
            end
        end
    end

    // Pure decode of registers, so reset clears it asynchronously and req never glitches it.
    assign gnt = (state_q == DRIVE) ? winner_oh_q : '0;

    // NOTE: FIFO storage is deliberately not reset; the head outputs are
    // forced to zero while empty, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= bus_in;
            mem_src[wr_ptr]  <= winner_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= PW'(next_index(int'(wr_ptr), DEPTH));
            end
            if (pop) begin
                rd_ptr <= PW'(next_index(int'(rd_ptr), DEPTH));
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign out_valid = (count != '0);
    assign out_data  = out_valid ? mem_data[rd_ptr] : '0;
    assign out_src   = out_valid ? mem_src[rd_ptr]  : '0;

endmodule

// File: tb/tb_tristate_bus_reader.sv
// Self-checking bench for tristate_bus_reader: directed scenarios plus random
// traffic, compared cycle by cycle against a queue-based reference model.
module tb_tristate_bus_reader;

    localparam int N_SRC = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 2;
    localparam int SW    = $clog2(N_SRC);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N_SRC-1:0] req = '0;
    logic [N_SRC-1:0] gnt;
    logic [DW-1:0]    bus_in;
    logic [DW-1:0]    out_data;
    logic [SW-1:0]    out_src;
    logic             out_valid;
    logic             out_ready = 1'b0;

    logic [DW-1:0]    src_word [N_SRC];
    logic [DW-1:0]    float_val = '0;

    typedef struct {
        logic [DW-1:0] data;
        int            src;
    } entry_t;

    entry_t           m_q[$];
    int               m_ptr;
    int               m_gnt_idx;
    logic [N_SRC-1:0] prev_gnt;

    int n_checks = 0;
    int n_errors = 0;

    tristate_bus_reader #(
        .N_SRC(N_SRC),
        .DW   (DW),
        .DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .gnt      (gnt),
        .bus_in   (bus_in),
        .out_data (out_data),
        .out_src  (out_src),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    // Sources drive the bus only while granted; an undriven bus reads as noise.
    always_comb begin
        bus_in = float_val;
        if (gnt != '0) begin
            bus_in = '0;
            for (int i = 0; i < N_SRC; i++) begin
                if (gnt[SW'(i)]) bus_in = bus_in | src_word[SW'(i)];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ptr     = 0;
        m_gnt_idx = -1;
        prev_gnt  = '0;
    endtask

    // One cycle of the bus rules: a grant cycle is always followed by a quiet
    // cycle; the granted word enters the queue at the end of its grant cycle.
    task automatic model_step();
        bit pop;
        int nxt;
        int c;
        pop = (m_q.size() > 0) && out_ready;
        nxt = -1;
        if (m_gnt_idx < 0 && req != '0 && (m_q.size() < DEPTH || pop)) begin
            for (int k = 0; k < N_SRC; k++) begin
                c = (m_ptr + k) % N_SRC;
                if (nxt < 0 && ((req >> c) & N_SRC'(1)) != '0) nxt = c;
            end
        end
        if (pop) void'(m_q.pop_front());
        if (m_gnt_idx >= 0) begin
            m_q.push_back('{data: src_word[SW'(m_gnt_idx)], src: m_gnt_idx});
            m_ptr = (m_gnt_idx + 1) % N_SRC;
        end
        m_gnt_idx = nxt;
    endtask

    task automatic compare_outputs();
        logic [N_SRC-1:0] e_gnt;
        e_gnt = (m_gnt_idx >= 0) ? (N_SRC'(1) << m_gnt_idx) : '0;
        check("gnt", 32'(gnt), 32'(e_gnt));
        check("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            check("out_data", 32'(out_data), 32'(m_q[0].data));
            check("out_src", 32'(out_src), 32'(m_q[0].src));
        end
        check("gnt_onehot", 32'($countones(gnt) <= 1), 32'(1));
        check("gnt_gap", 32'(prev_gnt != '0 && gnt != '0), 32'(0));
        prev_gnt = gnt;
    endtask

    // Inputs are set at the negedge before calling; outputs checked at the next negedge.
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_gnt", 32'(gnt), 32'(0));
        check("rst_valid", 32'(out_valid), 32'(0));
        check("rst_data", 32'(out_data), 32'(0));
        check("rst_src", 32'(out_src), 32'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int grants;
    int g_order[$];
    logic [DW-1:0] o_order[$];

    initial begin
        for (int i = 0; i < N_SRC; i++) src_word[i] = '0;
        @(negedge clk);

        // Single source request
        do_reset();
        out_ready   = 1'b1;
        src_word[1] = 8'hA5;
        req         = 4'b0010;
        tick();
        check("s1_gnt_on", 32'(gnt), 32'h2);
        req = '0;
        tick();
        check("s1_gnt_off", 32'(gnt), 32'h0);
        check("s1_valid", 32'(out_valid), 32'h1);
        check("s1_data", 32'(out_data), 32'hA5);
        check("s1_src", 32'(out_src), 32'h1);
        tick();

        // All sources requesting continuously
        do_reset();
        for (int i = 0; i < N_SRC; i++) src_word[i] = DW'(8'h10 + i);
        out_ready = 1'b1;
        req       = 4'b1111;
        g_order.delete();
        o_order.delete();
        repeat (10) begin
            tick();
            for (int i = 0; i < N_SRC; i++) if (gnt[SW'(i)]) g_order.push_back(i);
            if (out_valid) o_order.push_back(out_data);
        end
        check("s2_ngrants", 32'(g_order.size()), 32'd5);
        check("s2_nout", 32'(o_order.size()), 32'd5);
        for (int k = 0; k < 5 && k < g_order.size(); k++)
            check("s2_order", 32'(g_order[k]), 32'(k % N_SRC));
        for (int k = 0; k < 5 && k < o_order.size(); k++)
            check("s2_out", 32'(o_order[k]), 32'(8'h10 + (k % N_SRC)));

        // Backpressure with a full FIFO
        do_reset();
        out_ready = 1'b0;
        req       = 4'b1111;
        grants    = 0;
        repeat (8) begin
            tick();
            if (gnt != '0) grants++;
        end
        check("s3_grants_full", 32'(grants), 32'd2);
        check("s3_valid", 32'(out_valid), 32'h1);
        grants    = 0;
        out_ready = 1'b1;
        tick();
        if (gnt != '0) grants++;
        out_ready = 1'b0;
        repeat (6) begin
            tick();
            if (gnt != '0) grants++;
        end
        check("s3_grants_after_pop", 32'(grants), 32'd1);

        // Simultaneous push and pop at count = DEPTH-1
        do_reset();
        out_ready   = 1'b0;
        src_word[0] = 8'h3C;
        src_word[1] = 8'hC3;
        req         = 4'b0001;
        tick();
        req = '0;
        tick();
        check("s4_head0", 32'(out_data), 32'h3C);
        req = 4'b0010;
        tick();
        out_ready = 1'b1;
        req       = '0;
        tick();
        check("s4_valid", 32'(out_valid), 32'h1);
        check("s4_head1", 32'(out_data), 32'hC3);
        check("s4_src1", 32'(out_src), 32'h1);
        out_ready = 1'b0;
        tick();
        check("s4_stable", 32'(out_data), 32'hC3);

        // Reset in the middle of a DRIVE cycle
        do_reset();
        out_ready = 1'b1;
        req       = 4'b0010;
        tick();
        req = '0;
        tick();
        req = 4'b0100;
        tick();
        check("s5_gnt_pre", 32'(gnt), 32'h4);
        rst_n = 1'b0;
        #1;
        check("s5_gnt_async", 32'(gnt), 32'h0);
        check("s5_valid_async", 32'(out_valid), 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b1010;
        tick();
        check("s5_first_grant", 32'(gnt), 32'h2);
        req = '0;
        repeat (3) tick();

        // Random traffic
        do_reset();
        repeat (3000) begin
            for (int i = 0; i < N_SRC; i++) begin
                if (m_gnt_idx == i) begin
                    if ($urandom_range(0, 1) == 0) req[SW'(i)] = 1'b0;
                end else begin
                    src_word[i] = DW'($urandom);
                    if (!req[SW'(i)] && $urandom_range(0, 9) < 3) req[SW'(i)] = 1'b1;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            float_val = DW'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
